// File: rtl/exception_status_unit.sv
// Exception status unit: maps overflowing writeback instructions to rstatus codes,
// queues them in a small FIFO and offers them as a valid/ready register-file write.
// Optional macro EXC_COUNTER_EN adds a saturating exc_count_o of accepted pushes.
module exception_status_unit #(
  parameter int DATA_WIDTH  = 32,
  parameter int DEPTH       = 4,
  parameter int RSTATUS_REG = 30,
  localparam int PW = $clog2(DEPTH),
  localparam int CW = PW + 1
) (
  input  logic                  clock_i,
  input  logic                  reset_n_i,
  input  logic                  wb_valid_i,
  input  logic [4:0]            wb_opcode_i,
  input  logic [4:0]            wb_aluop_i,
  input  logic                  wb_ovf_i,
  output logic                  exc_valid_o,
  input  logic                  exc_ready_i,
  output logic [DATA_WIDTH-1:0] exc_data_o,
  output logic [4:0]            exc_rd_o,
  input  logic                  clear_i,
  output logic                  lost_o,
`ifdef EXC_COUNTER_EN
  output logic [7:0]            exc_count_o,
`endif
  output logic [CW-1:0]         pending_o
);

  logic [DEPTH-1:0][2:0] mem_q;
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic                  lost_q, lost_d;
  logic [2:0]            ev_code;
  logic                  ev, full, empty, pop, push_ok, drop;
  logic                  unused_aluop_hi;

  assign unused_aluop_hi = ^wb_aluop_i[4:3];

  // Code 0 means "not recognised"; only aluop[2:0] selects the ALU operation.
  always_comb begin
    ev_code = 3'd0;
    if (wb_opcode_i == 5'b00101) begin
      ev_code = 3'd2;
    end else if (wb_opcode_i == 5'b00000) begin
      case (wb_aluop_i[2:0])
        3'b000:  ev_code = 3'd1;
        3'b001:  ev_code = 3'd3;
        3'b110:  ev_code = 3'd4;
        3'b111:  ev_code = 3'd5;
        default: ev_code = 3'd0;
      endcase
    end
  end

  assign ev      = wb_valid_i & wb_ovf_i & (ev_code != 3'd0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign empty   = (cnt_q == '0);
  assign pop     = ~empty & exc_ready_i;
  // A pop frees the head slot, so a push into a full FIFO still lands.
  assign push_ok = ev & (~full | pop);
  assign drop    = ev & full & ~pop;

  always_comb begin
    wr_ptr_d = wr_ptr_q + PW'(push_ok);
    rd_ptr_d = rd_ptr_q + PW'(pop);
    lost_d   = lost_q | drop;
    cnt_d    = cnt_q;
    case ({push_ok, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  always_ff @(posedge clock_i) begin
    if (!reset_n_i) begin
      mem_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      lost_q   <= 1'b0;
    end else if (clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      lost_q   <= 1'b0;
    end else begin
      if (push_ok) mem_q[wr_ptr_q] <= ev_code;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      lost_q   <= lost_d;
    end
  end

`ifdef EXC_COUNTER_EN
  logic [7:0] exc_count_q, exc_count_d;

  always_comb begin
    exc_count_d = exc_count_q;
    if (push_ok && exc_count_q != 8'hFF) exc_count_d = exc_count_q + 8'd1;
  end

  always_ff @(posedge clock_i) begin
    if (!reset_n_i || clear_i) exc_count_q <= 8'd0;
    else                       exc_count_q <= exc_count_d;
  end

  assign exc_count_o = exc_count_q;
`endif

  assign exc_valid_o = ~empty;
  assign exc_data_o  = empty ? '0 : DATA_WIDTH'(mem_q[rd_ptr_q]);
  assign exc_rd_o    = 5'(RSTATUS_REG);
  assign lost_o      = lost_q;
  assign pending_o   = cnt_q;

endmodule

// File: tb/tb_exception_status_unit.sv
// Randomised plus directed bench for exception_status_unit against a queue-based model.
module tb_exception_status_unit;
  localparam int DW = 32;
  localparam int DEPTH = 4;
  localparam int CW = $clog2(DEPTH) + 1;

  logic clock = 0;
  logic reset_n = 0, wb_valid = 0, wb_ovf = 0, exc_ready = 0, clear = 0;
  logic [4:0] wb_opcode = 0, wb_aluop = 0;
  logic exc_valid, lost;
  logic [DW-1:0] exc_data;
  logic [4:0] exc_rd;
  logic [CW-1:0] pending;
`ifdef EXC_COUNTER_EN
  logic [7:0] exc_count;
`endif

  exception_status_unit #(.DATA_WIDTH(DW), .DEPTH(DEPTH), .RSTATUS_REG(30)) dut (
    .clock_i(clock), .reset_n_i(reset_n), .wb_valid_i(wb_valid),
    .wb_opcode_i(wb_opcode), .wb_aluop_i(wb_aluop), .wb_ovf_i(wb_ovf),
    .exc_valid_o(exc_valid), .exc_ready_i(exc_ready), .exc_data_o(exc_data),
    .exc_rd_o(exc_rd), .clear_i(clear), .lost_o(lost),
`ifdef EXC_COUNTER_EN
    .exc_count_o(exc_count),
`endif
    .pending_o(pending));

  always #5 clock = ~clock;

  int errors = 0, checks = 0;
  bit run = 0;
  int q[$];
  bit lost_m = 0;
  int cnt_m = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int code_of(input logic [4:0] op, input logic [4:0] alu);
    if (op == 5'd5) return 2;
    if (op != 5'd0) return 0;
    case (alu[2:0])
      3'd0: return 1;
      3'd1: return 3;
      3'd6: return 4;
      3'd7: return 5;
      default: return 0;
    endcase
  endfunction

  // One clock: drive inputs, advance the model on the edge, land just after negedge.
  task automatic cyc(input logic v, input logic [4:0] op, input logic [4:0] alu,
                     input logic ovf, input logic rdy, input logic clr, input logic rst);
    int code;
    wb_valid = v; wb_opcode = op; wb_aluop = alu; wb_ovf = ovf;
    exc_ready = rdy; clear = clr; reset_n = rst;
    code = code_of(op, alu);
    @(posedge clock);
    if (!rst || clr) begin
      q.delete(); lost_m = 0; cnt_m = 0;
    end else begin
      if (q.size() > 0 && rdy) void'(q.pop_front());
      if (v && ovf && code != 0) begin
        if (q.size() < DEPTH) begin
          q.push_back(code);
          if (cnt_m < 255) cnt_m++;
        end else lost_m = 1;
      end
    end
    @(negedge clock);
    #1;
  endtask

  task automatic idle(input logic rdy);
    cyc(0, 0, 0, 0, rdy, 0, 1);
  endtask

  always @(negedge clock) begin
    if (run) begin
      chk("exc_valid", 32'(exc_valid), 32'(q.size() != 0));
      chk("exc_data", exc_data, (q.size() != 0) ? 32'(q[0]) : 32'd0);
      chk("exc_rd", 32'(exc_rd), 32'd30);
      chk("pending", 32'(pending), 32'(q.size()));
      chk("lost", 32'(lost), 32'(lost_m));
`ifdef EXC_COUNTER_EN
      chk("exc_count", 32'(exc_count), 32'(cnt_m));
`endif
    end
  end

  initial begin
    cyc(0, 0, 0, 0, 0, 0, 0);
    cyc(0, 0, 0, 0, 0, 0, 0);
    chk("reset_valid", 32'(exc_valid), 0);
    chk("reset_pending", 32'(pending), 0);
    chk("reset_data", exc_data, 0);
    chk("reset_lost", 32'(lost), 0);
    run = 1;

    // add overflow -> code 1 next cycle, then accepted
    cyc(1, 5'd0, 5'd0, 1, 1, 0, 1);
    chk("add_valid", 32'(exc_valid), 1);
    chk("add_data", exc_data, 1);
    chk("add_rd", 32'(exc_rd), 30);
    idle(1);
    chk("add_drained", 32'(exc_valid), 0);

    // addi without and with overflow
    cyc(1, 5'd5, 5'd0, 0, 0, 0, 1);
    chk("addi_noovf", 32'(pending), 0);
    cyc(1, 5'd5, 5'd0, 1, 0, 0, 1);
    chk("addi_data", exc_data, 2);
    idle(1);

    // fill with ready low: sub, mul, div, add, addi (last dropped)
    cyc(1, 0, 5'd1, 1, 0, 0, 1);
    cyc(1, 0, 5'd6, 1, 0, 0, 1);
    cyc(1, 0, 5'd7, 1, 0, 0, 1);
    cyc(1, 0, 5'd0, 1, 0, 0, 1);
    cyc(1, 5'd5, 0, 1, 0, 0, 1);
    chk("full_pending", 32'(pending), 4);
    chk("full_lost", 32'(lost), 1);
    chk("order0", exc_data, 3);
    idle(1); chk("order1", exc_data, 4);
    idle(1); chk("order2", exc_data, 5);
    idle(1); chk("order3", exc_data, 1);
    idle(1); chk("order_empty", 32'(exc_valid), 0);

    // full + simultaneous div push and pop
    cyc(0, 0, 0, 0, 0, 1, 1);
    repeat (4) cyc(1, 0, 5'd0, 1, 0, 0, 1);
    cyc(1, 0, 5'd7, 1, 1, 0, 1);
    chk("pushpop_pending", 32'(pending), 4);
    chk("pushpop_lost", 32'(lost), 0);
    idle(1); idle(1); idle(1);
    chk("pushpop_last", exc_data, 5);
    idle(1);

    // clear with concurrent event
    cyc(1, 0, 5'd1, 1, 0, 0, 1);
    cyc(1, 0, 5'd6, 1, 0, 0, 1);
    cyc(1, 0, 5'd7, 1, 0, 1, 1);
    chk("clear_pending", 32'(pending), 0);
    chk("clear_valid", 32'(exc_valid), 0);
    chk("clear_lost", 32'(lost), 0);

    // reset mid-offer
    cyc(1, 0, 5'd0, 1, 0, 0, 1);
    cyc(1, 0, 5'd0, 1, 0, 0, 0);
    chk("rst_valid", 32'(exc_valid), 0);
    chk("rst_data", exc_data, 0);
    chk("rst_pending", 32'(pending), 0);

    // saturating counter
    repeat (300) cyc(1, 0, 5'd0, 1, 1, 0, 1);
`ifdef EXC_COUNTER_EN
    chk("count_sat", 32'(exc_count), 255);
`endif
    idle(1);

    for (int i = 0; i < 3000; i++) begin
      logic [4:0] op, alu;
      int sel = $urandom_range(0, 9);
      op  = (sel < 5) ? 5'd0 : (sel < 8) ? 5'd5 : 5'($urandom);
      alu = 5'($urandom);
      cyc(1'($urandom), op, alu, ($urandom_range(0, 3) != 0),
          ($urandom_range(0, 2) == 0), ($urandom_range(0, 49) == 0),
          ($urandom_range(0, 199) != 0));
    end

    run = 0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/exception_status_unit.md
EXCEPTION_STATUS_UNIT -- requirements
Module: exception_status_unit

Interface
REQ-001 Parameter DATA_WIDTH, default 32, width of rstatus data written to register file.
REQ-002 Parameter DEPTH, default 4, pending-exception FIFO entries; power of two, 2..16.
REQ-003 Parameter RSTATUS_REG, default 30, destination register index reported on exc_rd.
REQ-004 clock  input  1  single clock; all state updates on rising edge.
REQ-005 reset_n  input  1  synchronous, active-low reset.
REQ-006 wb_valid  input  1  writeback stage holds a retiring instruction this cycle.
REQ-007 wb_opcode  input  5  writeback opcode.
REQ-008 wb_aluop  input  5  writeback ALU op (meaningful for opcode 00000).
REQ-009 wb_ovf  input  1  ALU/multdiv overflow or divide-by-zero flag for the retiring instruction.
REQ-010 exc_valid  output  1  an rstatus write is offered.
REQ-011 exc_ready  input  1  register-file write port accepts the offer this cycle.
REQ-012 exc_data  output  DATA_WIDTH  rstatus value, code zero-extended.
REQ-013 exc_rd  output  5  always RSTATUS_REG.
REQ-014 clear  input  1  flush all pending entries and sticky flags.
REQ-015 lost  output  1  sticky: an exception was dropped because FIFO was full.
REQ-016 pending  output  clog2(DEPTH)+1  current FIFO occupancy.

Function
REQ-017 Exception event = wb_valid & wb_ovf & recognised instruction; all other cycles push nothing.
REQ-018 Code map: opcode 00101 (addi) -> 2; opcode 00000 with aluop[2:0] 000 add -> 1, 001 sub -> 3, 110 mul -> 4, 111 div -> 5; any other opcode/aluop is not recognised.
REQ-019 Events push one code into the FIFO; entries pop in arrival order.
REQ-020 exc_valid = (pending != 0); exc_data = code at FIFO head; transfer occurs when exc_valid & exc_ready on a rising edge.
REQ-021 exc_data and exc_valid shall remain stable while exc_valid=1 and exc_ready=0.
REQ-022 Latency: event in cycle N -> exc_valid=1 with that code in cycle N+1 when FIFO was empty.
REQ-023 Push and pop in the same cycle shall both occur, occupancy unchanged, including when full.
REQ-024 Push when full without simultaneous pop: event dropped, lost set to 1, existing entries unchanged.
REQ-025 Read/write pointers wrap modulo DEPTH; occupancy never exceeds DEPTH nor underflows.
REQ-026 clear has priority over push and pop: next cycle pending=0, exc_valid=0, lost=0; an event in the clear cycle is discarded.
REQ-027 exc_ready while exc_valid=0 shall have no effect.

Reset
REQ-028 With reset_n=0 at a rising edge: pending=0, exc_valid=0, exc_data=0, lost=0, pointers=0, counter=0.
REQ-029 Reset overrides clear, push and pop; an in-progress offer is abandoned without transfer.
REQ-030 exc_rd is constant RSTATUS_REG regardless of reset.

Configuration
REQ-031 Macro EXC_COUNTER_EN: when defined, add output exc_count[7:0], incremented once per accepted push (not dropped events), saturating at 255, cleared by reset or clear.
REQ-032 Without EXC_COUNTER_EN, exc_count port and its logic are absent; all other behaviour identical.

Verification
REQ-033 add overflow (opcode 0, aluop 000, wb_ovf=1), exc_ready=1 -> next cycle exc_valid=1, exc_data=1, exc_rd=30; accepted, then exc_valid=0.
REQ-034 addi overflow with wb_ovf=0 -> no push; with wb_ovf=1 -> exc_data=2.
REQ-035 exc_ready=0, events sub, mul, div, add, addi (DEPTH=4) -> pending=4, lost=1; release ready -> codes 3,4,5,1 in order, then empty.
REQ-036 FIFO full, simultaneous event (div) and pop -> pending stays 4, lost unchanged, div (5) emerges last.
REQ-037 Two pending entries, clear and an event asserted same cycle -> pending=0, exc_valid=0, lost=0 next cycle.
REQ-038 reset_n=0 mid-offer with exc_ready=0 -> all outputs at reset values next cycle; with EXC_COUNTER_EN, 300 accepted events -> exc_count=255.
